// File: rtl/lowpass_pkg.sv
// Shared types and constants for the click-free lowpass select controller.
package lowpass_pkg;

  // Sequencer states: fade out, swap the code, let the biquad settle, fade in.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_OUT = 3'd1,
    SWAP     = 3'd2,
    MUTE     = 3'd3,
    FADE_IN  = 3'd4
  } lp_sw_state_t;

  // Lowpass select codes. Code 0 bypasses the filter.
  localparam logic [2:0] FILT_ALLPASS = 3'd0;
  localparam logic [2:0] FILT_1K      = 3'd1;
  localparam logic [2:0] FILT_2K5     = 3'd2;
  localparam logic [2:0] FILT_5K      = 3'd3;
  localparam logic [2:0] FILT_10K     = 3'd4;

  localparam int DEF_NUM_FILTERS = 5;

  // Unknown codes fall back to allpass rather than selecting garbage coefficients.
  function automatic logic [2:0] clamp_sel(input logic [2:0] code, input int num_filters);
    if (int'(code) >= num_filters) begin
      return FILT_ALLPASS;
    end else begin
      return code;
    end
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// Debouncer for a multi-bit select input: a value is accepted only after it
// has been seen unchanged for DEBOUNCE consecutive cycles.
module sel_debounce #(
  parameter int W        = 3,
  parameter int DEBOUNCE = 2400
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in,
  output logic [W-1:0] out,
  output logic         stable_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  // Accept on the cycle the counter would reach its terminal value.
  localparam logic [CW-1:0] CNT_ARM  = CW'(DEBOUNCE - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [W-1:0]  prev_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  out_r;
  logic          stable_pulse_r;

  // Track the previous sample, count equal cycles and latch the accepted value once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r         <= '0;
      cnt_r          <= '0;
      out_r          <= '0;
      stable_pulse_r <= 1'b0;
    end else begin
      prev_r <= in;
      if (in != prev_r) begin
        cnt_r          <= '0;
        stable_pulse_r <= 1'b0;
      end else if (cnt_r == CNT_ARM) begin
        cnt_r          <= CNT_LAST;
        out_r          <= in;
        stable_pulse_r <= 1'b1;
      end else if (cnt_r == CNT_LAST) begin
        stable_pulse_r <= 1'b0;
      end else begin
        cnt_r          <= cnt_r + CW'(1);
        stable_pulse_r <= 1'b0;
      end
    end
  end

  assign out          = out_r;
  assign stable_pulse = stable_pulse_r;

endmodule

// File: rtl/lowpass_switch_ctrl.sv
// Owns the lowpass select code: a debounced request change fades the audio to
// silence, swaps the code, holds mute while the biquad settles, then fades back.
module lowpass_switch_ctrl
  import lowpass_pkg::*;
#(
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int DEBOUNCE    = 2400,
  parameter int RAMP_LOG2   = 6,
  parameter int SETTLE      = 32
) (
  input  logic        clk_48,
  input  logic        reset_n,
  input  logic [2:0]  filter_req,
  input  logic [15:0] audio_in,
  output logic [15:0] audio_out,
  output logic [2:0]  filter,
  output logic        busy
);

  localparam int GW = RAMP_LOG2 + 1;        // gain spans 0..2**RAMP_LOG2
  localparam int PW = 16 + RAMP_LOG2 + 1;   // signed product width, never overflows
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [GW-1:0] UNITY       = GW'(1 << RAMP_LOG2);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  lp_sw_state_t       state_r;
  logic [GW-1:0]      gain_r;
  logic [2:0]         filter_r;
  logic [2:0]         target_r;
  logic [SW-1:0]      settle_cnt_r;
  logic               busy_r;
  logic [15:0]        audio_out_r;

  logic [2:0]         deb_sel_s;
  logic               deb_pulse_s;
  logic signed [PW-1:0] audio_in_x_s;
  logic signed [PW-1:0] gain_x_s;
  logic signed [PW-1:0] prod_s;

  sel_debounce #(
    .W        (3),
    .DEBOUNCE (DEBOUNCE)
  ) u_sel_debounce (
    .clk          (clk_48),
    .rst_n        (reset_n),
    .in           (filter_req),
    .out          (deb_sel_s),
    .stable_pulse (deb_pulse_s)
  );

  // Load the range-checked request when the debouncer accepts a new value.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      target_r <= FILT_ALLPASS;
    end else if (deb_pulse_s) begin
      target_r <= clamp_sel(deb_sel_s, NUM_FILTERS);
    end else begin
      target_r <= target_r;
    end
  end

  // Sequencer: gain ramps and the code swap; filter only moves while gain is zero.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      gain_r       <= UNITY;
      filter_r     <= FILT_ALLPASS;
      settle_cnt_r <= '0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (target_r != filter_r) begin
            state_r <= FADE_OUT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        FADE_OUT: begin
          // Always runs to silence, even if the request reverts meanwhile.
          if (gain_r <= GW'(1)) begin
            gain_r  <= '0;
            state_r <= SWAP;
          end else begin
            gain_r  <= gain_r - GW'(1);
          end
        end
        SWAP: begin
          filter_r     <= target_r;
          settle_cnt_r <= '0;
          state_r      <= MUTE;
        end
        MUTE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            // A request that moved during the mute gets its own swap now.
            state_r <= (target_r != filter_r) ? SWAP : FADE_IN;
          end else begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
          end
        end
        FADE_IN: begin
          if (target_r != filter_r) begin
            // Turn around from the current gain so the envelope stays continuous.
            state_r <= FADE_OUT;
            gain_r  <= (gain_r == '0) ? '0 : gain_r - GW'(1);
          end else if (gain_r >= UNITY - GW'(1)) begin
            gain_r  <= UNITY;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            gain_r  <= gain_r + GW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          gain_r  <= UNITY;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign audio_in_x_s = {{(PW-16){audio_in[15]}}, audio_in};
  assign gain_x_s     = {{(PW-GW){1'b0}}, gain_r};
  assign prod_s       = audio_in_x_s * gain_x_s;

  // Apply the fade gain; at unity the shift returns audio_in unchanged.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      audio_out_r <= 16'd0;
    end else begin
      audio_out_r <= 16'(prod_s >>> RAMP_LOG2);
    end
  end

  assign audio_out = audio_out_r;
  assign filter    = filter_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_lowpass_switch_ctrl.sv
// Directed bench for lowpass_switch_ctrl: pass-through table, full transitions,
// bounce rejection, out-of-range codes, fade-in reversal and async reset.
module tb_lowpass_switch_ctrl;

  localparam int DEBOUNCE_T = 2400;
  localparam int RAMP_T     = 6;
  localparam int SETTLE_T   = 32;
  localparam int FULL_T     = DEBOUNCE_T + 64 + 1 + SETTLE_T + 64;

  logic        clk_48 = 1'b0;
  logic        reset_n;
  logic [2:0]  filter_req;
  logic [15:0] audio_in;
  logic [15:0] audio_out;
  logic [2:0]  filter;
  logic        busy;

  // Second instance with a short debounce so two acceptances can land inside one sequence.
  logic [2:0]  req_f;
  logic [15:0] ain_f;
  logic [15:0] aout_f;
  logic [2:0]  filt_f;
  logic        busy_f;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk_48 = ~clk_48;

  lowpass_switch_ctrl dut (
    .clk_48     (clk_48),
    .reset_n    (reset_n),
    .filter_req (filter_req),
    .audio_in   (audio_in),
    .audio_out  (audio_out),
    .filter     (filter),
    .busy       (busy)
  );

  lowpass_switch_ctrl #(.DEBOUNCE(16)) dut_fast (
    .clk_48     (clk_48),
    .reset_n    (reset_n),
    .filter_req (req_f),
    .audio_in   (ain_f),
    .audio_out  (aout_f),
    .filter     (filt_f),
    .busy       (busy_f)
  );

  typedef struct {
    logic [15:0] ain;
    logic [15:0] exp_out;
    logic [2:0]  exp_filter;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [0:11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  // At unity gain audio_out must reproduce audio_in one sample later.
  task automatic run_table(input string tag);
    for (int i = 0; i < 12; i++) begin
      audio_in = vecs[i].ain;
      tick();
      check({tag, "_out"}, int'(audio_out), int'(vecs[i].exp_out));
      check({tag, "_filter"}, int'(filter), int'(vecs[i].exp_filter));
      check({tag, "_busy"}, int'(busy), int'(vecs[i].exp_busy));
    end
  endtask

  // Full request-driven transition with constant audio amplitude amp.
  task automatic run_transition(input logic [2:0] req, input int amp, input int exp_filt,
                                input string tag);
    int k;
    int zc;
    int old_filt;
    int exp_v;
    old_filt   = int'(filter);
    audio_in   = amp[15:0];
    filter_req = req;
    k = 0;
    while (!busy && k < 3000) begin tick(); k++; end
    check_range({tag, "_busy_rise"}, k, DEBOUNCE_T - 5, DEBOUNCE_T + 10);
    zc = 0;
    while (int'($signed(audio_out)) == amp && zc < 10) begin tick(); k++; zc++; end
    check_range({tag, "_fade_start"}, zc, 0, 3);
    for (int g = 63; g >= 0; g--) begin
      if (g != 63) begin tick(); k++; end
      exp_v = (amp * g) >>> RAMP_T;
      check({tag, "_fade_out"}, int'($signed(audio_out)), exp_v);
      if (g == 1) check({tag, "_filter_hold"}, int'(filter), old_filt);
      if (g == 0) check({tag, "_filter_swap"}, int'(filter), exp_filt);
    end
    zc = 1;
    while (zc < 60) begin
      tick(); k++;
      if (audio_out != 16'd0) break;
      zc++;
    end
    check_range({tag, "_mute_len"}, zc, SETTLE_T, SETTLE_T + 4);
    for (int g = 1; g <= 64; g++) begin
      if (g != 1) begin tick(); k++; end
      exp_v = (amp * g) >>> RAMP_T;
      check({tag, "_fade_in"}, int'($signed(audio_out)), exp_v);
    end
    check({tag, "_busy_fall"}, int'(busy), 0);
    check({tag, "_filter_final"}, int'(filter), exp_filt);
    check_range({tag, "_total_time"}, k, FULL_T - 5, FULL_T + 11);
  endtask

  initial begin
    int viol;
    int filt_viol;
    int keep_filt;
    int cur;
    int prev;
    int step;
    int prev_filt;
    int peak;
    int rev_step;
    int i;
    bit rising;
    bit reversed;

    vecs[0]  = '{16'h0000, 16'h0000, 3'd0, 1'b0};
    vecs[1]  = '{16'h0001, 16'h0001, 3'd0, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 3'd0, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h7FFF, 3'd0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h8000, 3'd0, 1'b0};
    vecs[5]  = '{16'h4000, 16'h4000, 3'd0, 1'b0};
    vecs[6]  = '{16'hC000, 16'hC000, 3'd0, 1'b0};
    vecs[7]  = '{16'h0040, 16'h0040, 3'd0, 1'b0};
    vecs[8]  = '{16'hFFC1, 16'hFFC1, 3'd0, 1'b0};
    for (int j = 9; j < 12; j++) begin
      vecs[j].ain        = 16'($urandom);
      vecs[j].exp_out    = vecs[j].ain;
      vecs[j].exp_filter = 3'd0;
      vecs[j].exp_busy   = 1'b0;
    end

    reset_n    = 1'b0;
    filter_req = 3'd0;
    audio_in   = 16'd0;
    req_f      = 3'd0;
    ain_f      = 16'h4000;
    tick(); tick(); tick();
    check("reset_filter", int'(filter), 0);
    check("reset_audio_out", int'(audio_out), 0);
    check("reset_busy", int'(busy), 0);
    reset_n = 1'b1;

    // Scenario 1: request held at 0, unity pass-through.
    run_table("s1");

    // Scenario 2: 0 -> 3 with a constant 16384 input.
    run_transition(3'd3, 16384, 3, "s2");

    // Scenario 3: a request bouncing every 100 cycles is never accepted.
    viol = 0;
    keep_filt = int'(filter);
    for (int k = 0; k < 10000; k++) begin
      filter_req = (((k / 100) % 2) != 0) ? 3'd1 : 3'd2;
      tick();
      if (busy || int'(filter) != keep_filt) viol++;
    end
    check("s3_bounce_ignored", viol, 0);
    run_transition(3'd2, 12345, 2, "s3");

    // Scenario 4: code 7 is out of range and maps to allpass.
    run_transition(3'd4, 16384, 4, "s4a");
    run_transition(3'd7, -1000, 0, "s4b");

    // Scenario 5: a new request accepted mid fade-in reverses the ramp.
    req_f = 3'd1;
    i = 0;
    while (!busy_f && i < 100) begin tick(); i++; end
    check_range("s5_busy_rise", i, 14, 24);
    prev      = int'($signed(aout_f));
    prev_filt = int'(filt_f);
    viol = 0; filt_viol = 0; peak = 0; rev_step = 0;
    rising = 1'b0; reversed = 1'b0;
    for (i = 0; i < 600 && busy_f; i++) begin
      if (i == 100) req_f = 3'd4;
      tick();
      cur  = int'($signed(aout_f));
      step = cur - prev;
      if (step > 256 || step < -256) viol++;
      if (step > 0) rising = 1'b1;
      if (rising && step < 0 && !reversed) begin
        reversed = 1'b1;
        rev_step = step;
        peak     = prev;
      end
      if (int'(filt_f) != prev_filt && cur != 0) filt_viol++;
      prev      = cur;
      prev_filt = int'(filt_f);
    end
    check("s5_max_step", viol, 0);
    check("s5_reversed", int'(reversed), 1);
    check("s5_reverse_step", rev_step, -256);
    check_range("s5_reverse_peak", peak, 10 * 256, 30 * 256);
    check("s5_filter_moves_muted", filt_viol, 0);
    tick();
    check("s5_final_out", int'($signed(aout_f)), 16384);
    check("s5_final_filter", int'(filt_f), 4);
    check("s5_final_busy", int'(busy_f), 0);

    // Scenario 6: asynchronous reset in the middle of the mute.
    audio_in   = 16'h4000;
    filter_req = 3'd1;
    i = 0;
    while (!busy && i < 3000) begin tick(); i++; end
    check("s6_busy_rise", int'(busy), 1);
    i = 0;
    while (filter != 3'd1 && i < 200) begin tick(); i++; end
    check("s6_swapped", int'(filter), 1);
    tick(); tick(); tick(); tick(); tick();
    check("s6_muted", int'(audio_out), 0);
    #3;
    reset_n    = 1'b0;
    filter_req = 3'd0;
    #1;
    check("s6_async_filter", int'(filter), 0);
    check("s6_async_busy", int'(busy), 0);
    check("s6_async_audio_out", int'(audio_out), 0);
    tick(); tick();
    reset_n = 1'b1;
    run_table("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
